// File: rtl/ctrl_seq_pkg.sv
// Shared constants and types for the control-register sequencer:
// FSM encoding, error codes, AXI response codes and the table entry layout.
package ctrl_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;
    localparam logic [2:0] ST_FINISH  = 3'd6;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RESP     = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } seq_entry_t;

    function automatic logic resp_ok(input logic [1:0] resp);
        return (resp == RESP_OKAY);
    endfunction

endpackage

// File: rtl/ctrl_seq_table.sv
// Sequence table: DEPTH entries of {addr, data}, synchronous write,
// asynchronous read, cleared by reset.
module ctrl_seq_table
    import ctrl_seq_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          s_axi_aclk,
    input  logic          s_axi_areset,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  seq_entry_t    wr_ent,
    input  logic [IW-1:0] rd_idx,
    output seq_entry_t    rd_ent
);

    seq_entry_t mem_r [DEPTH];

    // Entry storage with whole-array clear on reset
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[wr_idx] <= wr_ent;
        end
    end

    assign rd_ent = mem_r[rd_idx];

endmodule

// File: rtl/ctrl_reg_sequencer.sv
// AXI-Lite master that replays a table of register writes, optionally
// verifying each by readback, with per-handshake timeout and abort.
module ctrl_reg_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter  int DEPTH   = 16,
    parameter  int TIMEOUT = 255,
    parameter  int VERIFY  = 1,
    localparam int IW      = $clog2(DEPTH)
) (
    input  logic          s_axi_aclk,
    input  logic          s_axi_areset,
    input  logic          tbl_we,
    input  logic [IW-1:0] tbl_idx,
    input  logic [31:0]   tbl_addr,
    input  logic [31:0]   tbl_data,
    input  logic [IW:0]   seq_len,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [IW-1:0] err_idx,
    output logic [31:0]   m_axi_awaddr,
    output logic          m_axi_awvalid,
    input  logic          m_axi_awready,
    output logic [31:0]   m_axi_wdata,
    output logic [3:0]    m_axi_wstrb,
    output logic          m_axi_wvalid,
    input  logic          m_axi_wready,
    input  logic [1:0]    m_axi_bresp,
    input  logic          m_axi_bvalid,
    output logic          m_axi_bready,
    output logic [31:0]   m_axi_araddr,
    output logic          m_axi_arvalid,
    input  logic          m_axi_arready,
    input  logic [31:0]   m_axi_rdata,
    input  logic [1:0]    m_axi_rresp,
    input  logic          m_axi_rvalid,
    output logic          m_axi_rready
);

    localparam int LW = IW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [IW-1:0] idx_r;
    logic [LW-1:0] len_r;
    logic          abort_pend_r;
    seq_entry_t    cur_ent_r;
    logic          aw_done_r, w_done_r;
    logic          awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
    logic          busy_r, done_r, err_r;
    logic [1:0]    err_code_r;
    logic [IW-1:0] err_idx_r;

    logic [IW-1:0] rd_idx_s;
    seq_entry_t    tbl_wr_ent_s, tbl_rd_ent_s, nxt_ent_s;
    logic [LW-1:0] len_clamp_s;
    logic          aw_hs_s, w_hs_s, timeout_s, last_s;

    assign tbl_wr_ent_s = '{addr: tbl_addr, data: tbl_data};

    ctrl_seq_table #(.DEPTH(DEPTH)) u_table (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_areset (s_axi_areset),
        .we           (tbl_we),
        .wr_idx       (tbl_idx),
        .wr_ent       (tbl_wr_ent_s),
        .rd_idx       (rd_idx_s),
        .rd_ent       (tbl_rd_ent_s)
    );

    // The entry is fetched only when leaving IDLE or NEXT; a same-cycle table
    // write to that entry is forwarded so late updates are not lost.
    assign rd_idx_s    = (state_r == ST_NEXT) ? (idx_r + IW'(1)) : '0;
    assign nxt_ent_s   = (tbl_we && (tbl_idx == rd_idx_s)) ? tbl_wr_ent_s : tbl_rd_ent_s;
    assign len_clamp_s = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
    assign aw_hs_s     = awvalid_r & m_axi_awready;
    assign w_hs_s      = wvalid_r & m_axi_wready;
    assign timeout_s   = (cnt_r == CW'(TIMEOUT));
    assign last_s      = (({1'b0, idx_r} + LW'(1)) == len_r);

    // Sequencer FSM, AXI channel control and status registers
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            idx_r        <= '0;
            len_r        <= '0;
            abort_pend_r <= 1'b0;
            cur_ent_r    <= '0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= ERR_NONE;
            err_idx_r    <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
            if (abort && busy_r) begin
                abort_pend_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (start) begin
                        done_r     <= (len_clamp_s == '0);
                        err_r      <= 1'b0;
                        err_code_r <= ERR_NONE;
                        err_idx_r  <= '0;
                        if (len_clamp_s != '0) begin
                            busy_r       <= 1'b1;
                            idx_r        <= '0;
                            len_r        <= len_clamp_s;
                            abort_pend_r <= 1'b0;
                            cur_ent_r    <= nxt_ent_s;
                            awvalid_r    <= 1'b1;
                            wvalid_r     <= 1'b1;
                            aw_done_r    <= 1'b0;
                            w_done_r     <= 1'b0;
                            state_r      <= ST_WR_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                        bready_r <= 1'b1;
                        cnt_r    <= '0;
                        state_r  <= ST_WR_RESP;
                    end else if (timeout_s) begin
                        awvalid_r  <= 1'b0;
                        wvalid_r   <= 1'b0;
                        err_code_r <= ERR_TIMEOUT;
                        err_idx_r  <= idx_r;
                        cnt_r      <= '0;
                        state_r    <= ST_FINISH;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_r <= 1'b0;
                        cnt_r    <= '0;
                        if (!resp_ok(m_axi_bresp)) begin
                            err_code_r <= ERR_RESP;
                            err_idx_r  <= idx_r;
                            state_r    <= ST_FINISH;
                        end else if (VERIFY != 0) begin
                            arvalid_r <= 1'b1;
                            state_r   <= ST_RD_REQ;
                        end else begin
                            state_r <= ST_NEXT;
                        end
                    end else if (timeout_s) begin
                        bready_r   <= 1'b0;
                        err_code_r <= ERR_TIMEOUT;
                        err_idx_r  <= idx_r;
                        cnt_r      <= '0;
                        state_r    <= ST_FINISH;
                    end
                end
                ST_RD_REQ: begin
                    if (m_axi_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= ST_RD_RESP;
                    end else if (timeout_s) begin
                        arvalid_r  <= 1'b0;
                        err_code_r <= ERR_TIMEOUT;
                        err_idx_r  <= idx_r;
                        cnt_r      <= '0;
                        state_r    <= ST_FINISH;
                    end
                end
                ST_RD_RESP: begin
                    if (m_axi_rvalid) begin
                        rready_r <= 1'b0;
                        cnt_r    <= '0;
                        if (!resp_ok(m_axi_rresp)) begin
                            err_code_r <= ERR_RESP;
                            err_idx_r  <= idx_r;
                            state_r    <= ST_FINISH;
                        end else if (m_axi_rdata != cur_ent_r.data) begin
                            err_code_r <= ERR_MISMATCH;
                            err_idx_r  <= idx_r;
                            state_r    <= ST_FINISH;
                        end else begin
                            state_r <= ST_NEXT;
                        end
                    end else if (timeout_s) begin
                        rready_r   <= 1'b0;
                        err_code_r <= ERR_TIMEOUT;
                        err_idx_r  <= idx_r;
                        cnt_r      <= '0;
                        state_r    <= ST_FINISH;
                    end
                end
                ST_NEXT: begin
                    cnt_r <= '0;
                    if (last_s || abort_pend_r) begin
                        state_r <= ST_FINISH;
                    end else begin
                        idx_r     <= idx_r + IW'(1);
                        cur_ent_r <= nxt_ent_s;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        state_r   <= ST_WR_REQ;
                    end
                end
                ST_FINISH: begin
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    err_r   <= (err_code_r != ERR_NONE);
                    state_r <= ST_IDLE;
                end
                default: begin
                    cnt_r     <= '0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign err_code      = err_code_r;
    assign err_idx       = err_idx_r;
    assign m_axi_awaddr  = cur_ent_r.addr;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = cur_ent_r.data;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign m_axi_araddr  = cur_ent_r.addr;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_ctrl_reg_sequencer.sv
// Directed bench for ctrl_reg_sequencer: behavioural AXI-Lite slave with
// knobs for delays and faults, plus a write/read scoreboard.
module tb_ctrl_reg_sequencer;
    import ctrl_seq_pkg::*;

    localparam int DEPTH = 16;
    localparam int IW    = 4;
    localparam int TO    = 10;

    logic          s_axi_aclk = 1'b0;
    logic          s_axi_areset = 1'b1;
    logic          tbl_we = 1'b0;
    logic [IW-1:0] tbl_idx = '0;
    logic [31:0]   tbl_addr = '0, tbl_data = '0;
    logic [IW:0]   seq_len = '0;
    logic          start = 1'b0, abort = 1'b0;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [IW-1:0] err_idx;
    logic [31:0]   m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic          m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic [31:0]   m_axi_rdata = '0;

    ctrl_reg_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TO), .VERIFY(1)) dut (
        .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .seq_len(seq_len), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    // slave knobs, written by the main sequence only
    int          aw_delay = 0;
    bit          ar_block = 1'b0;
    bit          bad_en = 1'b0;
    logic [31:0] bad_addr = '0;
    logic [31:0] corrupt = '0;

    // slave-owned state and observation logs
    logic [63:0] wr_log[$];
    logic [31:0] rd_log[$];
    logic [31:0] mem [logic [31:0]];
    int          awv_hi = 0, wv_hi = 0, aw_cnt = 0;
    bit          aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] aw_a = '0, w_d = '0;
    logic        awv_p = 1'b0, wv_p = 1'b0, bready_p = 1'b0, arv_p = 1'b0, rready_p = 1'b0;
    logic [31:0] awaddr_p = '0, wdata_p = '0, araddr_p = '0;

    // AXI-Lite slave: settle last posedge's handshakes, then drive for the next one
    always @(negedge s_axi_aclk) begin
        if (s_axi_areset) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
            m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
            aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0;
            awv_p = 1'b0; wv_p = 1'b0; bready_p = 1'b0; arv_p = 1'b0; rready_p = 1'b0;
        end else begin
            if (m_axi_awready && awv_p) begin aw_got = 1'b1; aw_a = awaddr_p; aw_cnt = 0; end
            if (m_axi_wready && wv_p) begin w_got = 1'b1; w_d = wdata_p; end
            if (m_axi_bvalid && bready_p) m_axi_bvalid = 1'b0;
            if (m_axi_rvalid && rready_p) m_axi_rvalid = 1'b0;
            if (m_axi_arready && arv_p) begin
                rd_log.push_back(araddr_p);
                m_axi_rdata  = (mem.exists(araddr_p) ? mem[araddr_p] : 32'h0) ^ corrupt;
                m_axi_rresp  = RESP_OKAY;
                m_axi_rvalid = 1'b1;
            end
            if (aw_got && w_got && !m_axi_bvalid) begin
                mem[aw_a] = w_d;
                wr_log.push_back({aw_a, w_d});
                m_axi_bresp  = (bad_en && aw_a == bad_addr) ? RESP_SLVERR : RESP_OKAY;
                m_axi_bvalid = 1'b1;
                aw_got = 1'b0; w_got = 1'b0;
            end
            awv_hi += int'(m_axi_awvalid);
            wv_hi  += int'(m_axi_wvalid);
            awv_p = m_axi_awvalid; awaddr_p = m_axi_awaddr;
            wv_p = m_axi_wvalid; wdata_p = m_axi_wdata;
            bready_p = m_axi_bready; rready_p = m_axi_rready;
            arv_p = m_axi_arvalid; araddr_p = m_axi_araddr;
            m_axi_awready = m_axi_awvalid && !aw_got && (aw_cnt >= aw_delay);
            if (m_axi_awvalid && !aw_got) aw_cnt++;
            m_axi_wready  = m_axi_wvalid && !w_got;
            m_axi_arready = m_axi_arvalid && !ar_block && !m_axi_rvalid;
        end
    end

    int checks = 0, errors = 0;
    logic [63:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    int wr_base = 0, rd_base = 0;
    int busy_cyc, ar_first, ec3_first, aw0, w0;
    bit timed_out, found;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        s_axi_areset = 1'b1;
        repeat (2) @(negedge s_axi_aclk);
        s_axi_areset = 1'b0;
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
        @(negedge s_axi_aclk);
        tbl_we = 1'b1; tbl_idx = IW'(i); tbl_addr = a; tbl_data = d;
        @(negedge s_axi_aclk);
        tbl_we = 1'b0;
    endtask

    task automatic run(input logic [IW:0] len, input int abort_at);
        @(negedge s_axi_aclk);
        seq_len = len; start = 1'b1;
        @(negedge s_axi_aclk);
        start = 1'b0;
        busy_cyc = 0; ar_first = -1; ec3_first = -1; timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            abort = (c == abort_at);
            busy_cyc += int'(busy);
            if (m_axi_arvalid && ar_first < 0) ar_first = c;
            if (err_code == ERR_TIMEOUT && ec3_first < 0) ec3_first = c;
            if (done) begin timed_out = 1'b0; break; end
            @(negedge s_axi_aclk);
        end
        abort = 1'b0;
        chk("run_completes", timed_out, 1'b0);
    endtask

    task automatic check_sb(input string tag);
        int i;
        chk({tag, "_wr_count"}, wr_log.size() - wr_base, exp_wr_q.size());
        chk({tag, "_rd_count"}, rd_log.size() - rd_base, exp_rd_q.size());
        i = wr_base;
        while (exp_wr_q.size() > 0) begin
            chk({tag, "_wr_txn"}, (i < wr_log.size()) ? wr_log[i] : 64'hDEAD_DEAD_DEAD_DEAD,
                exp_wr_q.pop_front());
            i++;
        end
        i = rd_base;
        while (exp_rd_q.size() > 0) begin
            chk({tag, "_rd_txn"}, (i < rd_log.size()) ? {32'h0, rd_log[i]} : 64'hDEAD,
                {32'h0, exp_rd_q.pop_front()});
            i++;
        end
        wr_base = wr_log.size();
        rd_base = rd_log.size();
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e,
                              input logic [1:0] c, input logic [IW-1:0] ix);
        chk({tag, "_status"}, {busy, done, err, err_code, err_idx}, {1'b0, d, e, c, ix});
    endtask

    initial begin
        do_reset();
        chk("reset_status", {busy, done, err, err_code, err_idx}, 9'h0);
        chk("reset_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'h0);

        // three entries, zero-wait slave
        load(0, 32'h00, 32'h1); load(1, 32'h04, 32'hABCD); load(2, 32'h08, 32'hFF);
        exp_wr_q = '{{32'h00, 32'h1}, {32'h04, 32'hABCD}, {32'h08, 32'hFF}};
        exp_rd_q = '{32'h00, 32'h04, 32'h08};
        run(5'd3, -1);
        chk_status("t1", 1'b1, 1'b0, ERR_NONE, 4'd0);
        chk("t1_busy_len", (busy_cyc >= 10 && busy_cyc <= 20), 1'b1);
        check_sb("t1");

        // awready delayed three cycles, wready immediate
        aw_delay = 3;
        load(0, 32'h10, 32'h5A5A);
        exp_wr_q = '{{32'h10, 32'h5A5A}};
        exp_rd_q = '{32'h10};
        aw0 = awv_hi; w0 = wv_hi;
        run(5'd1, -1);
        aw_delay = 0;
        chk("t2_awvalid_cycles", awv_hi - aw0, 4);
        chk("t2_wvalid_cycles", wv_hi - w0, 1);
        chk_status("t2", 1'b1, 1'b0, ERR_NONE, 4'd0);
        check_sb("t2");

        // SLVERR on entry 1
        bad_en = 1'b1; bad_addr = 32'h24;
        load(0, 32'h20, 32'h11); load(1, 32'h24, 32'h22); load(2, 32'h28, 32'h33);
        exp_wr_q = '{{32'h20, 32'h11}, {32'h24, 32'h22}};
        exp_rd_q = '{32'h20};
        run(5'd3, -1);
        bad_en = 1'b0;
        chk_status("t3", 1'b1, 1'b1, ERR_RESP, 4'd1);
        check_sb("t3");

        // arready never comes
        ar_block = 1'b1;
        load(0, 32'h30, 32'h5);
        exp_wr_q = '{{32'h30, 32'h5}};
        run(5'd1, -1);
        ar_block = 1'b0;
        chk_status("t4", 1'b1, 1'b1, ERR_TIMEOUT, 4'd0);
        chk("t4_timeout_delay", (ar_first >= 0 && ec3_first - ar_first >= 10 && ec3_first - ar_first <= 12), 1'b1);
        chk("t4_arvalid_dropped", m_axi_arvalid, 1'b0);
        check_sb("t4");

        // abort during entry 0 of 4
        for (int i = 0; i < 4; i++) load(i, 32'h60 + 32'(4 * i), 32'h100 + 32'(i));
        exp_wr_q = '{{32'h60, 32'h100}};
        exp_rd_q = '{32'h60};
        run(5'd4, 1);
        chk_status("t5", 1'b1, 1'b0, ERR_NONE, 4'd0);
        check_sb("t5");

        // readback mismatch
        corrupt = 32'h1;
        load(0, 32'h34, 32'h1234);
        exp_wr_q = '{{32'h34, 32'h1234}};
        exp_rd_q = '{32'h34};
        run(5'd1, -1);
        corrupt = '0;
        chk_status("t6", 1'b1, 1'b1, ERR_MISMATCH, 4'd0);
        check_sb("t6");

        // zero-length sequence
        run(5'd0, -1);
        chk_status("t7", 1'b1, 1'b0, ERR_NONE, 4'd0);
        chk("t7_busy_never", busy_cyc, 0);
        check_sb("t7");

        // seq_len above DEPTH clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            load(i, 32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            exp_wr_q.push_back({32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i)});
            exp_rd_q.push_back(32'h200 + 32'(4 * i));
        end
        run(5'd20, -1);
        chk_status("t8", 1'b1, 1'b0, ERR_NONE, 4'd0);
        check_sb("t8");

        // reset asserted while in WR_RESP
        load(0, 32'h40, 32'h77);
        exp_wr_q = '{{32'h40, 32'h77}};
        @(negedge s_axi_aclk);
        seq_len = 5'd1; start = 1'b1;
        @(negedge s_axi_aclk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m_axi_bready) begin found = 1'b1; break; end
            @(negedge s_axi_aclk);
        end
        chk("t9_reached_wr_resp", found, 1'b1);
        #2 s_axi_areset = 1'b1;
        #1;
        chk("t9_async_status", {busy, done, err, err_code, err_idx}, 9'h0);
        chk("t9_async_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'h0);
        repeat (2) @(negedge s_axi_aclk);
        s_axi_areset = 1'b0;
        check_sb("t9");

        // clean run after reset; entry 1 must read back as cleared
        load(0, 32'h50, 32'h99);
        exp_wr_q = '{{32'h50, 32'h99}, {32'h0, 32'h0}};
        exp_rd_q = '{32'h50, 32'h0};
        run(5'd2, -1);
        chk_status("t10", 1'b1, 1'b0, ERR_NONE, 4'd0);
        check_sb("t10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
